alsu_stream: RTL and testbench

Parametrised, pipelined successor of the team's 3-bit ALSU. It performs the same operation set on WIDTH-bit signed operands:
- OR / XOR, with optional reduction
- add, multiply
- shift, rotate
- bypass

It adds valid/ready handshakes on input and output, a 2-stage pipeline with backpressure, an explicit invalid flag and a saturating error counter. It sits between the stimulus/command source and the result consumer in the datapath.

---
 rtl/alsu_stream_if.sv | 38 +++
 rtl/alsu_stream.sv | 133 +++++++++++++
 tb/tb_alsu_stream.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_stream_if.sv
// alsu_stream_if: command and result streams of the pipelined ALSU.
//   master modport: command source / result consumer (drives the command
//                   fields, in_valid and out_ready).
//   slave modport:  the ALSU (drives in_ready, out_valid, out, invalid).
// The command fields are qualified by in_valid/in_ready. The result fields
// are qualified by out_valid/out_ready.
interface alsu_stream_if #(
    parameter int WIDTH = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           opcode;
    logic                 cin_in;
    logic                 serial_in;
    logic                 direction;
    logic                 red_op_a;
    logic                 red_op_b;
    logic                 bypass_a;
    logic                 bypass_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;
    logic                 invalid;

    modport master (
        output in_valid, a, b, opcode, cin_in, serial_in, direction,
               red_op_a, red_op_b, bypass_a, bypass_b, out_ready,
        input  in_ready, out_valid, out, invalid
    );

    modport slave (
        input  in_valid, a, b, opcode, cin_in, serial_in, direction,
               red_op_a, red_op_b, bypass_a, bypass_b, out_ready,
        output in_ready, out_valid, out, invalid
    );
endinterface

// File: rtl/alsu_stream.sv
// alsu_stream: two-stage pipelined ALSU on WIDTH-bit signed operands with
// valid/ready handshakes on both sides.
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   bus     alsu_stream_if slave: command stream in, result stream out
//   leds    zero after a valid result, inverted after each invalid result
//   err_cnt saturating count of invalid results
// Stage 1 registers the accepted command. Stage 2 computes the result and
// holds it in the output register. SHIFT and ROTATE take their operand from
// that output register, so they act on the previously loaded result.
module alsu_stream #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    parameter int    ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    alsu_stream_if.slave     bus,
    output logic [LED_W-1:0] leds,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int RW      = 2 * WIDTH;
    localparam bit PRIO_B  = (INPUT_PRIORITY == "B");
    localparam bit ADD_CIN = (FULL_ADDER == "ON");

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       opcode;
        logic             cin_in;
        logic             serial_in;
        logic             direction;
        logic             red_op_a;
        logic             red_op_b;
        logic             bypass_a;
        logic             bypass_b;
    } cmd_t;

    function automatic logic [RW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    cmd_t             cmd_in;
    cmd_t             s1;
    logic             s1_valid;
    logic             s2_load;
    logic             is_invalid;
    logic             use_red;
    logic [WIDTH-1:0] red_src;
    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [RW-1:0]    byp_val;
    logic [RW-1:0]    result;

    assign cmd_in = '{a: bus.a, b: bus.b, opcode: bus.opcode, cin_in: bus.cin_in,
                      serial_in: bus.serial_in, direction: bus.direction,
                      red_op_a: bus.red_op_a, red_op_b: bus.red_op_b,
                      bypass_a: bus.bypass_a, bypass_b: bus.bypass_b};

    // Stage 2 accepts whenever its current result is empty or being consumed,
    // and stage 1 frees up on the same edge, which gives one command per cycle.
    assign s2_load      = s1_valid && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_load;

    assign a_ext = sext(s1.a);
    assign b_ext = sext(s1.b);

    // Reduction flags are only legal with OR/XOR; opcodes 6 and 7 are unused.
    assign is_invalid = (s1.opcode[2:1] == 2'b11) ||
                        ((s1.red_op_a || s1.red_op_b) && (s1.opcode[2:1] != 2'b00));
    assign use_red    = s1.red_op_a || s1.red_op_b;
    assign red_src    = (s1.red_op_a && s1.red_op_b) ? (PRIO_B ? s1.b : s1.a)
                                                      : (s1.red_op_a ? s1.a : s1.b);
    assign byp_val    = (s1.bypass_a && s1.bypass_b) ? (PRIO_B ? b_ext : a_ext)
                                                      : (s1.bypass_a ? a_ext : b_ext);

    always_comb begin
        // NOTE: default first so every path assigns result and no latch is inferred.
        result = '0;
        case (s1.opcode)
            3'd0: result = use_red ? RW'(|red_src) : sext(s1.a | s1.b);
            3'd1: result = use_red ? RW'(^red_src) : sext(s1.a ^ s1.b);
            3'd2: result = a_ext + b_ext + RW'(ADD_CIN && s1.cin_in);
            // Low half of the product of sign-extended operands is the full
            // signed product, which always fits in 2*WIDTH bits.
            3'd3: result = a_ext * b_ext;
            3'd4: result = s1.direction ? {bus.out[RW-2:0], s1.serial_in}
                                        : {s1.serial_in, bus.out[RW-1:1]};
            3'd5: result = s1.direction ? {bus.out[RW-2:0], bus.out[RW-1]}
                                        : {bus.out[0], bus.out[RW-1:1]};
            default: result = '0;
        endcase
        // Bypass overrides every opcode; an invalid command overrides bypass.
        if (s1.bypass_a || s1.bypass_b) result = byp_val;
        if (is_invalid) result = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the stage-1 payload is cleared too, so no stale command
            // survives a reset even though s1_valid already qualifies it.
            s1            <= '0;
            s1_valid      <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.invalid   <= 1'b0;
            leds          <= '0;
            err_cnt       <= '0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                s1       <= cmd_in;
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                bus.out       <= result;
                bus.out_valid <= 1'b1;
                bus.invalid   <= is_invalid;
                leds          <= is_invalid ? ~leds : '0;
                if (is_invalid && (err_cnt != {ERR_W{1'b1}}))
                    err_cnt <= err_cnt + ERR_W'(1);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alsu_stream.sv
// tb_alsu_stream: drives two alsu_stream instances with one command stream.
//   dut0: defaults (INPUT_PRIORITY "A", FULL_ADDER "ON", ERR_W 8)
//   dut1: INPUT_PRIORITY "B", FULL_ADDER "OFF", ERR_W 2
// A queue-based model predicts each result in command order; a negedge
// process compares every valid output against the queue head. Directed
// sequences pin latency, backpressure, priorities, reset and saturation
// with literal values, followed by a randomized phase.
module tb_alsu_stream;
    localparam int W  = 3;
    localparam int RW = 2 * W;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   opcode;
        logic         cin;
        logic         serial;
        logic         dir;
        logic         ra;
        logic         rb;
        logic         ba;
        logic         bb;
    } cmd_t;

    typedef struct packed {
        logic [RW-1:0] out;
        logic          inv;
        logic [15:0]   leds;
        logic [7:0]    err;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_t cmd       = '0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b1;
    bit   rand_ready = 1'b0;

    alsu_stream_if #(.WIDTH(W)) bus0 ();
    alsu_stream_if #(.WIDTH(W)) bus1 ();

    assign {bus0.a, bus0.b, bus0.opcode, bus0.cin_in, bus0.serial_in, bus0.direction,
            bus0.red_op_a, bus0.red_op_b, bus0.bypass_a, bus0.bypass_b} = cmd;
    assign {bus1.a, bus1.b, bus1.opcode, bus1.cin_in, bus1.serial_in, bus1.direction,
            bus1.red_op_a, bus1.red_op_b, bus1.bypass_a, bus1.bypass_b} = cmd;
    assign bus0.in_valid  = in_valid;
    assign bus1.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus1.out_ready = out_ready;

    logic [15:0] leds0, leds1;
    logic [7:0]  err0;
    logic [1:0]  err1;

    alsu_stream #(.WIDTH(W)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .leds(leds0), .err_cnt(err0));

    alsu_stream #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_W(16), .ERR_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .leds(leds1), .err_cnt(err1));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one command from the operation rules, using integer arithmetic.
    function automatic logic [RW-1:0] model(input cmd_t c, input logic [RW-1:0] prev,
                                            input bit prio_b, input bit full_add,
                                            output bit inv);
        int sa, sb, v;
        logic [W-1:0] x;
        sa  = int'($signed(c.a));
        sb  = int'($signed(c.b));
        inv = (c.opcode >= 3'd6) || ((c.ra || c.rb) && (c.opcode > 3'd1));
        if (inv) return '0;
        if (c.ba || c.bb) begin
            v = (c.ba && c.bb) ? (prio_b ? sb : sa) : (c.ba ? sa : sb);
            return v[RW-1:0];
        end
        if ((c.opcode <= 3'd1) && (c.ra || c.rb)) begin
            x = (c.ra && c.rb) ? (prio_b ? c.b : c.a) : (c.ra ? c.a : c.b);
            return (c.opcode == 3'd0) ? RW'(|x) : RW'(^x);
        end
        case (c.opcode)
            3'd0: v = int'($signed(c.a | c.b));
            3'd1: v = int'($signed(c.a ^ c.b));
            3'd2: v = sa + sb + ((full_add && c.cin) ? 1 : 0);
            3'd3: v = sa * sb;
            3'd4: return c.dir ? {prev[RW-2:0], c.serial} : {c.serial, prev[RW-1:1]};
            default: return c.dir ? {prev[RW-2:0], prev[RW-1]} : {prev[0], prev[RW-1:1]};
        endcase
        return v[RW-1:0];
    endfunction

    res_t          q0[$];
    res_t          q1[$];
    logic [RW-1:0] m_last0, m_last1;
    logic [15:0]   m_leds0, m_leds1;
    int            m_err0, m_err1;

    // Handshake monitor: predicts at input acceptance, retires at consumption.
    always @(posedge clk) begin
        res_t r;
        bit   inv;
        if (rst) begin
            q0.delete(); q1.delete();
            m_last0 = '0; m_last1 = '0; m_leds0 = '0; m_leds1 = '0; m_err0 = 0; m_err1 = 0;
        end else begin
            check("in_ready_match", bus1.in_ready, bus0.in_ready);
            if (bus0.out_valid && out_ready && q0.size() > 0) void'(q0.pop_front());
            if (bus1.out_valid && out_ready && q1.size() > 0) void'(q1.pop_front());
            if (in_valid && bus0.in_ready) begin
                r.out = model(cmd, m_last0, 1'b0, 1'b1, inv);
                r.inv = inv;
                m_leds0 = inv ? ~m_leds0 : 16'h0;
                if (inv && m_err0 < 255) m_err0++;
                r.leds = m_leds0; r.err = 8'(m_err0); m_last0 = r.out;
                q0.push_back(r);
                r.out = model(cmd, m_last1, 1'b1, 1'b0, inv);
                r.inv = inv;
                m_leds1 = inv ? ~m_leds1 : 16'h0;
                if (inv && m_err1 < 3) m_err1++;
                r.leds = m_leds1; r.err = 8'(m_err1); m_last1 = r.out;
                q1.push_back(r);
            end
        end
    end

    // Output compare on every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid_match", bus1.out_valid, bus0.out_valid);
            if (bus0.out_valid) begin
                check("dut0_result_expected", q0.size() != 0, 1);
                if (q0.size() != 0) begin
                    check("dut0_out", bus0.out, q0[0].out);
                    check("dut0_invalid", bus0.invalid, q0[0].inv);
                    check("dut0_leds", leds0, q0[0].leds);
                    check("dut0_err_cnt", err0, q0[0].err);
                end
            end
            if (bus1.out_valid) begin
                check("dut1_result_expected", q1.size() != 0, 1);
                if (q1.size() != 0) begin
                    check("dut1_out", bus1.out, q1[0].out);
                    check("dut1_invalid", bus1.invalid, q1[0].inv);
                    check("dut1_leds", leds1, q1[0].leds);
                    check("dut1_err_cnt", err1, q1[0].err);
                end
            end
        end
    end

    function automatic cmd_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_t c;
        c = '0; c.opcode = op; c.a = a; c.b = b;
        return c;
    endfunction

    // Present c from a negedge and return just after the edge that accepts it.
    // in_valid stays high; the caller follows with another send() or idle().
    task automatic send(input cmd_t c);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cmd = c; in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (bus0.in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("accept_within_bound", ok, 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        bit   drained;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_out", bus0.out, 0);
        check("rst_invalid", bus0.invalid, 0);
        check("rst_leds", leds0, 0);
        check("rst_err_cnt", err0, 0);
        check("rst_in_ready", bus0.in_ready, 1);
        @(negedge clk); rst = 1'b0;

        // Latency and back-to-back throughput.
        c = mk(3'd2, 3'd3, 3'd3); c.cin = 1'b1;
        send(c);
        #1 check("lat_not_yet_valid", bus0.out_valid, 0);
        send(mk(3'd3, 3'b100, 3'b100));
        #1;
        check("add_valid", bus0.out_valid, 1);
        check("add_out", bus0.out, 6'd7);
        check("add_invalid", bus0.invalid, 0);
        check("add_leds", leds0, 16'h0000);
        check("add_no_cin_out", bus1.out, 6'd6);
        idle();
        #1;
        check("mul_out", bus0.out, 6'h10);
        check("mul_out_dut1", bus1.out, 6'h10);
        idle(); idle();

        // Invalid stream followed by a valid OR.
        send(mk(3'd6, 3'd1, 3'd2));
        c = mk(3'd2, 3'd1, 3'd2); c.ra = 1'b1;
        send(c);
        #1;
        check("inv1_out", bus0.out, 0);
        check("inv1_invalid", bus0.invalid, 1);
        check("inv1_leds", leds0, 16'hFFFF);
        check("inv1_err", err0, 1);
        send(mk(3'd7, 3'd1, 3'd2));
        #1;
        check("inv2_invalid", bus0.invalid, 1);
        check("inv2_leds", leds0, 16'h0000);
        check("inv2_err", err0, 2);
        send(mk(3'd0, 3'd1, 3'd2));
        #1;
        check("inv3_leds", leds0, 16'hFFFF);
        check("inv3_err", err0, 3);
        idle();
        #1;
        check("or_out", bus0.out, 6'd3);
        check("or_invalid", bus0.invalid, 0);
        check("or_leds", leds0, 16'h0000);
        check("or_err_kept", err0, 3);
        idle(); idle();

        // Backpressure: first result held, second in stage 1, third stalled.
        @(negedge clk); out_ready = 1'b0;
        send(mk(3'd2, 3'd1, 3'd1));
        send(mk(3'd1, 3'b101, 3'b011));
        @(negedge clk);
        cmd = mk(3'd3, 3'd3, 3'b111); in_valid = 1'b1;
        #1 check("stall_in_ready", bus0.in_ready, 0);
        repeat (3) begin
            @(negedge clk);
            check("stall_out_valid", bus0.out_valid, 1);
            check("stall_out_held", bus0.out, 6'd2);
            check("stall_in_ready_held", bus0.in_ready, 0);
        end
        @(negedge clk); out_ready = 1'b1;
        #1 check("release_in_ready", bus0.in_ready, 1);
        @(posedge clk);
        #1 check("release_second", bus0.out, 6'h3E);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk);
        #1 check("release_third", bus0.out, 6'h3D);
        @(posedge clk);
        #1 check("release_drained", bus0.out_valid, 0);

        // Shift/rotate chain on the output register.
        send(mk(3'd2, 3'd2, 3'd3));
        c = mk(3'd4, 3'd0, 3'd0); c.dir = 1'b1; c.serial = 1'b1;
        send(c);
        #1 check("chain_load", bus0.out, 6'b000101);
        c = mk(3'd5, 3'd0, 3'd0); c.dir = 1'b0;
        send(c);
        #1 check("chain_shift_left", bus0.out, 6'b001011);
        c = mk(3'd4, 3'd0, 3'b110); c.bb = 1'b1; c.dir = 1'b1; c.serial = 1'b1;
        send(c);
        #1 check("chain_rotate_right", bus0.out, 6'b100101);
        c = mk(3'd5, 3'b101, 3'd0); c.ba = 1'b1;
        send(c);
        #1 check("chain_bypass_b", bus0.out, 6'b111110);
        idle();
        #1 check("chain_bypass_a_sext", bus0.out, 6'b111101);
        idle(); idle();

        // Reduction and bypass priority.
        c = mk(3'd1, 3'b011, 3'b001); c.ra = 1'b1; c.rb = 1'b1;
        send(c);
        c = mk(3'd3, 3'b011, 3'b001); c.ba = 1'b1; c.bb = 1'b1;
        send(c);
        #1;
        check("red_prio_a", bus0.out, 6'd0);
        check("red_prio_b", bus1.out, 6'd1);
        idle();
        #1;
        check("byp_prio_a", bus0.out, 6'd3);
        check("byp_prio_b", bus1.out, 6'd1);
        idle(); idle();

        // Reset with a command in stage 1 only.
        send(mk(3'd2, 3'd1, 3'd2));
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus0.out_valid, 0);
        check("mid_rst_out", bus0.out, 0);
        check("mid_rst_leds", leds0, 0);
        check("mid_rst_err", err0, 0);
        check("mid_rst_in_ready", bus0.in_ready, 1);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1 check("no_stale_result", bus0.out_valid, 0);
        end

        // Error counter saturation.
        for (int i = 0; i < 5; i++) send(mk(3'd6, 3'd0, 3'd0));
        idle();
        #1;
        check("sat_err_w2", err1, 2'd3);
        check("err_w8_count", err0, 8'd5);
        check("sat_leds", leds0, 16'hFFFF);
        idle(); idle();

        // Randomized stream with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            c.a      = W'($urandom);
            c.b      = W'($urandom);
            c.opcode = 3'($urandom);
            c.cin    = 1'($urandom);
            c.serial = 1'($urandom);
            c.dir    = 1'($urandom);
            c.ra     = ($urandom_range(0, 5) == 0);
            c.rb     = ($urandom_range(0, 5) == 0);
            c.ba     = ($urandom_range(0, 5) == 0);
            c.bb     = ($urandom_range(0, 5) == 0);
            send(c);
            if ($urandom_range(0, 3) == 0) idle();
        end
        rand_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        drained = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (q0.size() == 0 && q1.size() == 0) begin drained = 1'b1; break; end
        end
        check("drain_within_bound", drained, 1);
        @(posedge clk);
        #1 check("final_idle", bus0.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
